// File: rtl/ccd_pkg.sv
// Shared CCD front-end types and default timing, common to the readout sequencer and master-clock generator.
// Pure declarations: no latency, no flow control.
package ccd_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ICG_PRE,
        SH_PULSE,
        SH_POST,
        READOUT,
        GAP
    } ccd_state_t;

    localparam int PIX_IDX_W    = 12;
    localparam int INTEG_W      = 24;

    localparam int MCLK_DIV     = 25;
    localparam int MCLK_PER_PIX = 4;
    localparam int NUM_PIXELS   = 3694;
    localparam int T_ICG_SH     = 25;
    localparam int SH_WIDTH     = 50;
    localparam int T_SH_ICG     = 50;
    localparam int SAMPLE_OFS   = 75;
endpackage

// File: rtl/ccd_readout_ctrl_pix_timer.sv
// Pixel-slot counter: wrap pulse on the final slot cycle, registered sample strobe at SAMPLE_OFS.
// The strobe lines up with the slot cycle it marks; free-running while run is high, no backpressure.
module ccd_pix_timer #(
    parameter int PIX_CYC    = 100,
    parameter int SAMPLE_OFS = 75
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic run,
    input  logic run_nxt,
    output logic wrap,
    output logic last_nxt,
    output logic sample
);
    localparam int CW = $clog2(PIX_CYC + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign wrap = run && (cnt == CW'(PIX_CYC - 1));

    // Counter restarts at 0 on every entry into readout.
    always_comb begin
        cnt_nxt = '0;
        if (run && run_nxt && !wrap)
            cnt_nxt = cnt + 1'b1;
        last_nxt = run_nxt && (cnt_nxt == CW'(PIX_CYC - 1));
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sample <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            sample <= run_nxt && (cnt_nxt == CW'(SAMPLE_OFS));
        end
    end
endmodule

// File: rtl/ccd_readout_ctrl.sv
// Linear-CCD frame sequencer: ICG/SH gate timing, then one ADC strobe per pixel slot. Registered outputs, busy from the start edge.
// No backpressure: start ignored while busy. CCD_CONT_MODE_EN adds free-running frames separated by integ_cycles until stop.
module ccd_readout_ctrl #(
    parameter int MCLK_DIV     = ccd_pkg::MCLK_DIV,
    parameter int MCLK_PER_PIX = ccd_pkg::MCLK_PER_PIX,
    parameter int NUM_PIXELS   = ccd_pkg::NUM_PIXELS,
    parameter int T_ICG_SH     = ccd_pkg::T_ICG_SH,
    parameter int SH_WIDTH     = ccd_pkg::SH_WIDTH,
    parameter int T_SH_ICG     = ccd_pkg::T_SH_ICG,
    parameter int SAMPLE_OFS   = ccd_pkg::SAMPLE_OFS
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [ccd_pkg::INTEG_W-1:0]   integ_cycles,
    output logic                          ccd_icg,
    output logic                          ccd_sh,
    output logic                          adc_sample,
    output logic [ccd_pkg::PIX_IDX_W-1:0] pixel_idx,
    output logic                          busy,
    output logic                          frame_done
);
    import ccd_pkg::*;

    localparam int PIX_CYC = MCLK_DIV * MCLK_PER_PIX;

    ccd_state_t           state, state_nxt;
    logic [INTEG_W-1:0]   phase_cnt, phase_cnt_nxt;
    logic [PIX_IDX_W-1:0] pix_nxt;
    logic                 icg_nxt, sh_nxt, busy_nxt, done_nxt;
    logic                 wrap, last_nxt, frame_end, last_pix;

    assign last_pix  = (pixel_idx == PIX_IDX_W'(NUM_PIXELS - 1));
    assign frame_end = wrap && last_pix;

`ifdef CCD_CONT_MODE_EN
    logic [INTEG_W-1:0] integ_q;
    logic               stop_seen;
    logic               stop_any;

    assign stop_any = stop_seen || stop;

    // A stop arriving with an accepted start also sticks, so that frame runs single.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            integ_q   <= '0;
            stop_seen <= 1'b0;
        end else begin
            if (state == IDLE && start)
                integ_q <= integ_cycles;
            stop_seen <= (state_nxt != IDLE) && (stop_seen || stop);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = stop ^ (^integ_cycles);
`endif

    ccd_pix_timer #(
        .PIX_CYC    (PIX_CYC),
        .SAMPLE_OFS (SAMPLE_OFS)
    ) u_pix_timer (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .run      (state == READOUT),
        .run_nxt  (state_nxt == READOUT),
        .wrap     (wrap),
        .last_nxt (last_nxt),
        .sample   (adc_sample)
    );

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ICG_PRE;
            ICG_PRE:  if (phase_cnt == INTEG_W'(T_ICG_SH - 1)) state_nxt = SH_PULSE;
            SH_PULSE: if (phase_cnt == INTEG_W'(SH_WIDTH - 1)) state_nxt = SH_POST;
            SH_POST:  if (phase_cnt == INTEG_W'(T_SH_ICG - 1)) state_nxt = READOUT;
            READOUT: begin
                if (frame_end) begin
`ifdef CCD_CONT_MODE_EN
                    if (stop_any)
                        state_nxt = IDLE;
                    else if (integ_q == '0)
                        state_nxt = ICG_PRE;
                    else
                        state_nxt = GAP;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            GAP: begin
`ifdef CCD_CONT_MODE_EN
                if (stop_any)
                    state_nxt = IDLE;
                else if (phase_cnt == integ_q - 1'b1)
                    state_nxt = ICG_PRE;
`else
                state_nxt = IDLE;
`endif
            end
            default:  state_nxt = IDLE;
        endcase

        phase_cnt_nxt = '0;
        if (state_nxt == state && state != IDLE && state != READOUT)
            phase_cnt_nxt = phase_cnt + 1'b1;
    end

    // Registered outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        icg_nxt  = !(state_nxt == ICG_PRE || state_nxt == SH_PULSE || state_nxt == SH_POST);
        sh_nxt   = (state_nxt == SH_PULSE);
        busy_nxt = (state_nxt != IDLE);
        pix_nxt  = pixel_idx;
        if (state_nxt == READOUT && state != READOUT)
            pix_nxt = '0;
        else if (wrap && !last_pix)
            pix_nxt = pixel_idx + 1'b1;
        done_nxt = last_nxt && (pix_nxt == PIX_IDX_W'(NUM_PIXELS - 1));
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            ccd_icg    <= 1'b1;
            ccd_sh     <= 1'b0;
            busy       <= 1'b0;
            pixel_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            ccd_icg    <= icg_nxt;
            ccd_sh     <= sh_nxt;
            busy       <= busy_nxt;
            pixel_idx  <= pix_nxt;
            frame_done <= done_nxt;
        end
    end
endmodule

// File: tb/tb_ccd_readout_ctrl.sv
// Scoreboard bench for ccd_readout_ctrl with a short pixel slot (PIX_CYC=8, 4 pixels) and default gate timing.
module tb_ccd_readout_ctrl;
    localparam int T_ICG_SH = 25;
    localparam int SH_W     = 50;
    localparam int T_SH_ICG = 50;
    localparam int PIX      = 8;
    localparam int NPIX     = 4;
    localparam int SOFS     = 3;
    localparam int FLEN     = T_ICG_SH + SH_W + T_SH_ICG + NPIX * PIX;  // 157

    localparam int E_BUSY_RISE = 0;
    localparam int E_ICG_FALL  = 1;
    localparam int E_SH_RISE   = 2;
    localparam int E_SH_FALL   = 3;
    localparam int E_ICG_RISE  = 4;
    localparam int E_SAMPLE    = 5;
    localparam int E_DONE      = 6;
    localparam int E_BUSY_FALL = 7;

    typedef struct {
        int kind;
        int cyc;
        int dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] integ_cycles = '0;
    logic        ccd_icg, ccd_sh, adc_sample, busy, frame_done;
    logic [11:0] pixel_idx;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    ev_t  sb[$];

    logic p_icg = 1'b1;
    logic p_sh = 1'b0;
    logic p_busy = 1'b0;

    ccd_readout_ctrl #(
        .MCLK_DIV     (2),
        .MCLK_PER_PIX (4),
        .NUM_PIXELS   (NPIX),
        .T_ICG_SH     (T_ICG_SH),
        .SH_WIDTH     (SH_W),
        .T_SH_ICG     (T_SH_ICG),
        .SAMPLE_OFS   (SOFS)
    ) dut (
        .clk_50m      (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .integ_cycles (integ_cycles),
        .ccd_icg      (ccd_icg),
        .ccd_sh       (ccd_sh),
        .adc_sample   (adc_sample),
        .pixel_idx    (pixel_idx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int kind, input int c, input int dat);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.dat  = dat;
        sb.push_back(e);
    endtask

    task automatic push_frame(input int k, input bit first, input bit last);
        if (first) push(E_BUSY_RISE, k, 0);
        push(E_ICG_FALL, k, 0);
        push(E_SH_RISE, k + T_ICG_SH, 0);
        push(E_SH_FALL, k + T_ICG_SH + SH_W, 0);
        push(E_ICG_RISE, k + T_ICG_SH + SH_W + T_SH_ICG, 0);
        for (int i = 0; i < NPIX; i++)
            push(E_SAMPLE, k + T_ICG_SH + SH_W + T_SH_ICG + SOFS + i * PIX, i);
        push(E_DONE, k + FLEN - 1, NPIX - 1);
        if (last) push(E_BUSY_FALL, k + FLEN, 0);
    endtask

    task automatic observe(input int kind, input int dat);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL event: got kind=%0d cyc=%0d dat=%0d, expected no event", kind, cyc, dat);
        end else begin
            e = sb.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.dat == dat)
                passes++;
            else
                $display("FAIL event: got kind=%0d cyc=%0d dat=%0d, expected kind=%0d cyc=%0d dat=%0d",
                         kind, cyc, dat, e.kind, e.cyc, e.dat);
        end
    endtask

    // Monitor: turns output edges and strobes into timestamped events.
    always @(negedge clk) begin
        if (!p_busy && busy)     observe(E_BUSY_RISE, 0);
        if (p_icg && !ccd_icg)   observe(E_ICG_FALL, 0);
        if (!p_sh && ccd_sh)     observe(E_SH_RISE, 0);
        if (p_sh && !ccd_sh)     observe(E_SH_FALL, 0);
        if (!p_icg && ccd_icg)   observe(E_ICG_RISE, 0);
        if (adc_sample)          observe(E_SAMPLE, int'(pixel_idx));
        if (frame_done)          observe(E_DONE, int'(pixel_idx));
        if (p_busy && !busy)     observe(E_BUSY_FALL, 0);
        p_icg  = ccd_icg;
        p_sh   = ccd_sh;
        p_busy = busy;
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic arm(input bit with_stop, input int integ, output int k);
        @(negedge clk);
        k            = cyc + 1;
        start        = 1'b1;
        stop         = with_stop;
        integ_cycles = 24'(integ);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int k;
        int k2;
        #1 rst = 1'b1;
        #3;
        chk("reset ccd_icg", int'(ccd_icg), 1);
        chk("reset ccd_sh", int'(ccd_sh), 0);
        chk("reset adc_sample", int'(adc_sample), 0);
        chk("reset pixel_idx", int'(pixel_idx), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // Plain single frame.
        arm(1'b0, 0, k);
        push_frame(k, 1'b1, 1'b1);
        release_start();
        wait_to(k + FLEN + 3);

        // start re-pulsed during the SH pulse and during readout is ignored.
        arm(1'b0, 0, k);
        push_frame(k, 1'b1, 1'b1);
        release_start();
        wait_to(k + 40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(k + 140);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(k + FLEN + 5);

        // start and stop together: a single frame in every build.
        arm(1'b1, 5, k);
        push_frame(k, 1'b1, 1'b1);
        release_start();
        wait_to(k + FLEN + 3);

        // Reset in the middle of the SH pulse.
        arm(1'b0, 0, k);
        push(E_BUSY_RISE, k, 0);
        push(E_ICG_FALL, k, 0);
        push(E_SH_RISE, k + T_ICG_SH, 0);
        release_start();
        wait_to(k + 40);
        push(E_SH_FALL, k + 41, 0);
        push(E_ICG_RISE, k + 41, 0);
        push(E_BUSY_FALL, k + 41, 0);
        #2 rst = 1'b1;
        #1;
        chk("midreset ccd_sh", int'(ccd_sh), 0);
        chk("midreset ccd_icg", int'(ccd_icg), 1);
        chk("midreset busy", int'(busy), 0);
        chk("midreset pixel_idx", int'(pixel_idx), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Clean frame after the reset.
        arm(1'b0, 0, k);
        push_frame(k, 1'b1, 1'b1);
        release_start();
        wait_to(k + FLEN + 3);

`ifdef CCD_CONT_MODE_EN
        // Continuous, gap of 10 cycles; stop during frame 2.
        arm(1'b0, 10, k);
        k2 = k + FLEN + 10;
        push_frame(k, 1'b1, 1'b0);
        push_frame(k2, 1'b0, 1'b1);
        release_start();
        wait_to(k2 + 50);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(k2 + FLEN + 5);

        // Continuous, zero gap: ICG falls the cycle after frame_done.
        arm(1'b0, 0, k);
        k2 = k + FLEN;
        push_frame(k, 1'b1, 1'b0);
        push_frame(k2, 1'b0, 1'b1);
        release_start();
        wait_to(k2 + 100);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_to(k2 + FLEN + 5);
`endif

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("events outstanding", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
